seg_disp_sched: RTL and testbench

SEG_DISP_SCHED -- requirements
Module: seg_disp_sched

---
 rtl/seg_disp_pkg.sv | 44 ++++
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_disp_sched.sv | 167 ++++++++++++++++
 tb/tb_seg_disp_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared types, segment table and round-robin helper for the display scheduler
package seg_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segments {a,b,c,d,e,f,g}, indexed by hex value
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } pick_t;

  // First requester strictly after the last owner, wrapping back to the last owner itself
  function automatic pick_t rr_pick(input logic [2:0] req, input logic [1:0] last);
    pick_t      p;
    logic [1:0] order [3];
    p = '0;
    case (last)
      2'd0:    begin order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd0; end
      2'd1:    begin order[0] = 2'd2; order[1] = 2'd0; order[2] = 2'd1; end
      default: begin order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; end
    endcase
    for (int k = 0; k < 3; k++) begin
      if (!p.valid && req[order[k]]) begin
        p.valid = 1'b1;
        p.idx   = order[k];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - hex nibble to active-low seven-segment pattern
module seg_hex_decode
  import seg_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_disp_sched.sv
// rtl/seg_disp_sched.sv - round-robin owner scheduler for a shared 4-digit seven-segment display
module seg_disp_sched
  import seg_disp_pkg::*;
#(
  parameter int SCAN_DIV = 96000,
  parameter int HOLD_CYC = 192000000
) (
  input  logic        ispclk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] dat0,
  input  logic [15:0] dat1,
  input  logic [15:0] dat2,
  output logic [2:0]  grant,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

  state_t              state;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [1:0]          idx;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [1:0]          owner;
  logic [1:0]          last_owner;
  logic [15:0]         shadow;

  pick_t               pick;
  logic [15:0]         pick_word;
  logic [15:0]         owner_word;
  logic [3:0]          nibble;
  logic [6:0]          seg_dec;
  logic                scan_wrap;
  logic                owner_req;
  logic                others_pending;

  function automatic logic [15:0] word_of(input logic [1:0] s, input logic [15:0] d0,
                                          input logic [15:0] d1, input logic [15:0] d2);
    case (s)
      2'd0:    return d0;
      2'd1:    return d1;
      default: return d2;
    endcase
  endfunction

  assign pick           = rr_pick(req, last_owner);
  assign pick_word      = word_of(pick.idx, dat0, dat1, dat2);
  assign owner_word     = word_of(owner, dat0, dat1, dat2);
  assign scan_wrap      = (scan_cnt == SCAN_LAST);
  assign owner_req      = req[owner];
  assign others_pending = |(req & ~(3'b001 << owner));

  // Select the shadow nibble for the digit currently being scanned
  always_comb begin
    nibble = shadow[3:0];
    case (idx)
      2'd0: nibble = shadow[3:0];
      2'd1: nibble = shadow[7:4];
      2'd2: nibble = shadow[11:8];
      2'd3: nibble = shadow[15:12];
      default: nibble = shadow[3:0];
    endcase
  end

  seg_hex_decode u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  // Ownership FSM with scan counters, shadow capture and registered display outputs
  always_ff @(posedge ispclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= 3'b000;
      seg        <= SEG_BLANK;
      an         <= 4'b1111;
      dp         <= 1'b1;
      scan_cnt   <= '0;
      idx        <= 2'd0;
      hold_cnt   <= '0;
      owner      <= 2'd0;
      last_owner <= 2'd2;
      shadow     <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          seg      <= SEG_BLANK;
          an       <= 4'b1111;
          dp       <= 1'b1;
          grant    <= 3'b000;
          scan_cnt <= '0;
          idx      <= 2'd0;
          if (pick.valid) begin
            state      <= ST_OWN;
            owner      <= pick.idx;
            last_owner <= pick.idx;
            grant      <= 3'b001 << pick.idx;
            hold_cnt   <= HOLD_LOAD;
            shadow     <= pick_word;
          end
        end

        ST_OWN: begin
          seg <= seg_dec;
          an  <= ~(4'b0001 << idx);
          dp  <= (idx != owner);
          if (scan_wrap) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
            // A new frame starts at digit 0, so refresh the shadow only here
            if (idx == 2'd3) shadow <= owner_word;
          end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
          end
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end else if (others_pending || !owner_req) begin
            state    <= others_pending ? ST_BLANK : ST_IDLE;
            grant    <= 3'b000;
            seg      <= SEG_BLANK;
            an       <= 4'b1111;
            dp       <= 1'b1;
            scan_cnt <= '0;
            idx      <= 2'd0;
          end
        end

        ST_BLANK: begin
          seg   <= SEG_BLANK;
          an    <= 4'b1111;
          dp    <= 1'b1;
          grant <= 3'b000;
          if (scan_wrap) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            if (pick.valid) begin
              state      <= ST_OWN;
              owner      <= pick.idx;
              last_owner <= pick.idx;
              grant      <= 3'b001 << pick.idx;
              hold_cnt   <= HOLD_LOAD;
              shadow     <= pick_word;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
          grant <= 3'b000;
          seg   <= SEG_BLANK;
          an    <= 4'b1111;
          dp    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_disp_sched.sv
// tb/tb_seg_disp_sched.sv - directed self-checking bench for seg_disp_sched
module tb_seg_disp_sched;

  logic        ispclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic [2:0]  req    = 3'b000;
  logic [15:0] dat0   = 16'h0000;
  logic [15:0] dat1   = 16'h0000;
  logic [15:0] dat2   = 16'h0000;
  logic [2:0]  grant;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  int n_cmp = 0;
  int n_bad = 0;

  int         cnt_own0, cnt_zero, an_bad;
  int         run, zrun, nseq, gap_bad, run_bad;
  logic [2:0] prev_g, g;
  logic [2:0] seq [8];

  seg_disp_sched #(.SCAN_DIV(4), .HOLD_CYC(20)) dut (
    .ispclk (ispclk),
    .rst_n  (rst_n),
    .req    (req),
    .dat0   (dat0),
    .dat1   (dat1),
    .dat2   (dat2),
    .grant  (grant),
    .seg    (seg),
    .an     (an),
    .dp     (dp)
  );

  always #5 ispclk = ~ispclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge ispclk);
  endtask

  task automatic restart();
    @(negedge ispclk);
    rst_n = 1'b0;
    req   = 3'b000;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) seq[i] = 3'b000;

    // reset values
    step(2);
    check("rst_grant", grant, 3'b000);
    check("rst_seg", seg, 7'b1111111);
    check("rst_an", an, 4'b1111);
    check("rst_dp", dp, 1'b1);
    rst_n = 1'b1;
    step(1);
    check("idle_grant", grant, 3'b000);

    // single source, digit scan order and decimal point
    req  = 3'b001;
    dat0 = 16'h0123;
    step(1);
    check("lat1_grant", grant, 3'b001);
    check("lat1_an", an, 4'b1111);
    step(1);
    check("d0_seg", seg, 7'b0000110);
    check("d0_an", an, 4'b1110);
    check("d0_dp", dp, 1'b0);
    step(4);
    check("d1_seg", seg, 7'b0010010);
    check("d1_an", an, 4'b1101);
    check("d1_dp", dp, 1'b1);
    step(4);
    check("d2_seg", seg, 7'b1001111);
    check("d2_an", an, 4'b1011);
    step(4);
    check("d3_seg", seg, 7'b0000001);
    check("d3_an", an, 4'b0111);

    // data change mid-frame appears only after the 3->0 wrap
    step(4);
    check("wrap_seg", seg, 7'b0000110);
    step(3);
    dat0 = 16'h89AB;
    step(1);
    check("notear_d1", seg, 7'b0010010);
    step(12);
    check("new_d0_seg", seg, 7'b1100000);
    check("new_d0_an", an, 4'b1110);
    step(4);
    check("new_d1_seg", seg, 7'b0001000);

    // asynchronous reset mid-ownership
    rst_n = 1'b0;
    #1;
    check("arst_grant", grant, 3'b000);
    check("arst_seg", seg, 7'b1111111);
    check("arst_an", an, 4'b1111);
    step(2);
    req   = 3'b000;
    rst_n = 1'b1;

    // sub-cycle request glitch still earns a grant
    step(1);
    #4 req = 3'b001;
    #2 req = 3'b000;
    step(1);
    check("glitch_grant", grant, 3'b001);

    // owner drops req early: held until timer expires, then idle
    restart();
    req = 3'b001;
    step(1);
    check("hold_g1", grant, 3'b001);
    step(4);
    req = 3'b000;
    step(15);
    check("hold_g20", grant, 3'b001);
    check("hold_an20", an, 4'b1110);
    step(1);
    check("drop_grant", grant, 3'b000);
    check("drop_an", an, 4'b1111);
    check("drop_seg", seg, 7'b1111111);

    // two requesters: hold, blank gap, hand over
    restart();
    req  = 3'b011;
    dat1 = 16'h4567;
    cnt_own0 = 0;
    cnt_zero = 0;
    an_bad   = 0;
    for (int c = 0; c < 24; c++) begin
      step(1);
      if (grant == 3'b001) cnt_own0++;
      if (grant == 3'b000) begin
        cnt_zero++;
        if (an != 4'b1111) an_bad++;
      end
    end
    check("own0_cycles", cnt_own0, 20);
    check("blank_cycles", cnt_zero, 4);
    check("blank_an_bad", an_bad, 0);
    step(1);
    check("handover", grant, 3'b010);
    step(1);
    check("s1_d0_seg", seg, 7'b0001111);
    check("s1_d0_dp", dp, 1'b1);
    step(4);
    check("s1_d1_seg", seg, 7'b0100000);
    check("s1_d1_dp", dp, 1'b0);
    check("s1_d1_an", an, 4'b1101);

    // three requesters held: round-robin rotation with blank gaps
    restart();
    req     = 3'b111;
    prev_g  = 3'b000;
    run     = 0;
    zrun    = 0;
    nseq    = 0;
    gap_bad = 0;
    run_bad = 0;
    for (int c = 0; c < 200; c++) begin
      step(1);
      g = grant;
      if (g != 3'b000) begin
        if (prev_g == 3'b000) begin
          if (nseq > 0 && zrun != 4) gap_bad++;
          if (nseq < 8) seq[nseq] = g;
          nseq++;
          run = 0;
        end else if (g != prev_g) begin
          gap_bad++;
        end
        run++;
      end else begin
        if (prev_g != 3'b000) begin
          if (run != 20) run_bad++;
          zrun = 0;
        end
        zrun++;
      end
      prev_g = g;
    end
    check("rr_seq0", seq[0], 3'b001);
    check("rr_seq1", seq[1], 3'b010);
    check("rr_seq2", seq[2], 3'b100);
    check("rr_seq3", seq[3], 3'b001);
    check("rr_gap_bad", gap_bad, 0);
    check("rr_run_bad", run_bad, 0);

    // reset during blank, then round-robin restarts at source 0
    restart();
    req = 3'b011;
    step(22);
    rst_n = 1'b0;
    #1;
    check("bl_rst_grant", grant, 3'b000);
    check("bl_rst_an", an, 4'b1111);
    check("bl_rst_seg", seg, 7'b1111111);
    check("bl_rst_dp", dp, 1'b1);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("post_rst_rr", grant, 3'b001);
    restart();
    req = 3'b100;
    step(1);
    check("post_rst_src2", grant, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
